tcm_sram: RTL and testbench
===========================

# tcm_sram

Parametrised, dual-port, synchronous-read tightly-coupled memory for the core. It replaces the single-port, combinational-read word store. Port A serves instruction fetch and is read-only. Port B serves load/store and is read/write with byte strobes. Each port has a request/grant handshake and a one-entry registered response slot with backpressure.

## Interface
Parameters:
- DATA_W, 32, word width in bits; a multiple of 8, power of two.
- DEPTH, 4096, number of words.
- ADDR_W, 32, byte-address width on both ports.
- INIT_FILE, "", hex image loaded at elaboration; empty means no preload.

Ports (x = a, b unless noted):
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- x_req_i  in  1  request valid
- x_gnt_o  out  1  request accepted this cycle when high together with x_req_i
- x_addr_i  in  ADDR_W  byte address
- b_we_i  in  1  write request (port B only)
- b_be_i  in  DATA_W/8  byte strobes (port B only)
- b_wdata_i  in  DATA_W  write data (port B only)
- x_rvalid_o  out  1  response valid
- x_rready_i  in  1  response consumed
- x_rdata_o  out  DATA_W  read data
- x_err_o  out  1  response carries an error

## Operation
- Byte offset width OFF = log2(DATA_W/8). Word index = addr[OFF+log2(DEPTH)-1:OFF].
- Error condition: misaligned (addr[OFF-1:0] != 0), or any address bit at or above OFF+log2(DEPTH) is set (out of range).
- Grant: x_gnt_o = !(x_rvalid_o && !x_rready_i). It is combinational. Accept = x_req_i && x_gnt_o.
- Accepted read: the next cycle, x_rvalid_o=1 and x_rdata_o = mem[index]. x_err_o=0.
- Accepted port B write, no error: mem[index] byte k is updated with b_wdata_i byte k wherever b_be_i[k]=1. A response is still produced: rvalid=1 next cycle, rdata = the pre-write word (read-first), err=0.
- b_be_i = 0 write: no change to memory. The response is produced normally.
- Error on any accepted access: memory is not modified. The response has rdata=0 and err=1.
- Response slot: it holds rvalid/rdata/err stable while rvalid && !rready. It clears to rvalid=0 on rready unless a new access is accepted in the same cycle, in which case it loads the new response (back-to-back throughput of 1 access per cycle).
- Same-word collision, A read with B write in the same cycle: A returns the old word.
- B write followed by any read of that word in the next cycle returns the new word.
- The two ports are fully independent otherwise. There is no arbitration and no stall between them.

## Timing
- Read latency is 1 cycle from the accept edge to rvalid. Memory update takes effect at the accept edge.
- Reset (rst_n=0 at a clk edge): x_rvalid_o=0, x_rdata_o=0, x_err_o=0. Pending responses are dropped. Any write presented in that cycle is not performed.
- x_gnt_o is 1 during and immediately after reset, because rvalid=0.
- Memory contents are not cleared by reset. Contents are INIT_FILE data, or X if INIT_FILE is empty.
- There is no combinational path from x_addr_i to x_rdata_o. x_gnt_o depends only on the response slot and x_rready_i.

## Test plan
- Preload word 5 = 0xDEADBEEF. A: req addr 0x14, rready=1 -> next cycle a_rvalid=1, a_rdata=0xDEADBEEF, a_err=0.
- B write addr 0x14, be=4'b0011, wdata=0x12345678 -> response rdata=0xDEADBEEF. Then B read 0x14 -> 0xDEAD5678.
- Same cycle: A read 0x20 and B write 0x20 = 0xA5A5A5A5, word 8 = 0x0 before -> a_rdata=0x0. A read 0x20 next cycle -> 0xA5A5A5A5.
- B write addr 0x4002 (misaligned) and B write addr 0x4000 (word 4096, DEPTH=4096) -> err=1, rdata=0, and a readback of words 0 and 4095 is unchanged.
- Backpressure on A: rready=0 with 3 queued requests -> first response held stable and a_gnt=0. Raise rready -> one response per cycle, in order, with no loss.
- Assert rst_n=0 in the cycle a B write to 0x8 = 0xFFFFFFFF is presented -> rvalid=0. Readback of word 2 shows its old value.

Source files
------------

// File: rtl/tcm_if.sv
// Request/grant plus registered-response bus for one TCM port.
// Port A uses slave_ro; its write fields are tied off by the master.
interface tcm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_i;
  logic                  gnt_o;
  logic [ADDR_W-1:0]     addr_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   be_i;
  logic [DATA_W-1:0]     wdata_i;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [DATA_W-1:0]     rdata_o;
  logic                  err_o;

  modport master (
    output req_i, addr_i, we_i,
    output be_i, wdata_i, rready_i,
    input  gnt_o, rvalid_o,
    input  rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i,
    input  be_i, wdata_i, rready_i,
    output gnt_o, rvalid_o,
    output rdata_o, err_o
  );

  modport slave_ro (
    input  req_i, addr_i, rready_i,
    output gnt_o, rvalid_o,
    output rdata_o, err_o
  );
endinterface

// File: rtl/tcm_sram.sv
// Dual-port synchronous-read TCM: A is fetch (read-only),
// B is load/store with byte strobes, both with a 1-deep response slot.
module tcm_sram #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 4096,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic     clk,
  input  logic     rst_n,
  tcm_if.slave_ro  a,
  tcm_if.slave     b
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int HI  = OFF + IW;
  localparam logic [ADDR_W-1:0] OMASK =
    ADDR_W'((64'd1 << OFF) - 64'd1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic          a_acc;
  logic          a_bad;
  logic [IW-1:0] a_idx;
  logic          b_acc;
  logic          b_bad;
  logic [IW-1:0] b_idx;

  // Grant only looks at the slot, never at the request.
  assign a.gnt_o = !(a.rvalid_o && !a.rready_i);
  assign b.gnt_o = !(b.rvalid_o && !b.rready_i);

  assign a_acc = a.req_i && a.gnt_o;
  assign b_acc = b.req_i && b.gnt_o;

  assign a_bad = (|(a.addr_i & OMASK))
              || (|(a.addr_i >> HI));
  assign b_bad = (|(b.addr_i & OMASK))
              || (|(b.addr_i >> HI));

  assign a_idx = a.addr_i[HI-1:OFF];
  assign b_idx = b.addr_i[HI-1:OFF];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a.rvalid_o <= 1'b0;
      a.rdata_o  <= '0;
      a.err_o    <= 1'b0;
    end else if (a_acc) begin
      a.rvalid_o <= 1'b1;
      a.err_o    <= a_bad;
      a.rdata_o  <= a_bad ? '0 : mem[a_idx];
    end else if (a.rready_i) begin
      a.rvalid_o <= 1'b0;
    end
  end

  // Read-first: the response carries the word before any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b.rvalid_o <= 1'b0;
      b.rdata_o  <= '0;
      b.err_o    <= 1'b0;
    end else if (b_acc) begin
      b.rvalid_o <= 1'b1;
      b.err_o    <= b_bad;
      b.rdata_o  <= b_bad ? '0 : mem[b_idx];
    end else if (b.rready_i) begin
      b.rvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && b_acc && b.we_i && !b_bad) begin
      for (int k = 0; k < NB; k++) begin
        if (b.be_i[k])
          mem[b_idx][8*k +: 8] <= b.wdata_i[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_tcm_sram.sv
// Directed plus random bench for tcm_sram against a
// word-array memory model and per-port response scoreboards.
module tb_tcm_sram;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic acc_a;
  logic acc_b;

  logic [31:0] mm [4096];
  rsp_t        qa [$];
  rsp_t        qb [$];

  tcm_if ia ();
  tcm_if ib ();

  tcm_sram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (ia),
    .b     (ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(logic [31:0] ad);
    return (ad % 4 != 0) || (ad >= 32'h4000);
  endfunction

  task automatic set_a(logic rq, logic [31:0] ad, logic rr);
    ia.req_i    = rq;
    ia.addr_i   = ad;
    ia.rready_i = rr;
  endtask

  task automatic set_b(logic rq, logic we, logic [31:0] ad,
                       logic [3:0] be, logic [31:0] wd,
                       logic rr);
    ib.req_i    = rq;
    ib.we_i     = we;
    ib.addr_i   = ad;
    ib.be_i     = be;
    ib.wdata_i  = wd;
    ib.rready_i = rr;
  endtask

  // One clock: check grant, advance model, check the slots.
  task automatic cyc();
    logic ga, gb;
    rsp_t r;
    int   w;
    #7;
    ga = !(qa.size() != 0 && !ia.rready_i);
    gb = !(qb.size() != 0 && !ib.rready_i);
    chk("a_gnt", 32'(ia.gnt_o), 32'(ga));
    chk("b_gnt", 32'(ib.gnt_o), 32'(gb));
    acc_a = ia.req_i && ga;
    acc_b = ib.req_i && gb;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      acc_a = 1'b0;
      acc_b = 1'b0;
    end else begin
      if (qa.size() != 0 && ia.rready_i)
        void'(qa.pop_front());
      if (qb.size() != 0 && ib.rready_i)
        void'(qb.pop_front());
      if (acc_a) begin
        r.e = bad_addr(ia.addr_i);
        r.d = r.e ? 32'h0 : mm[ia.addr_i / 4];
        qa.push_back(r);
      end
      if (acc_b) begin
        r.e = bad_addr(ib.addr_i);
        w   = int'(ib.addr_i / 4);
        r.d = r.e ? 32'h0 : mm[w];
        qb.push_back(r);
        if (!r.e && ib.we_i) begin
          for (int k = 0; k < 4; k++)
            if (ib.be_i[k])
              mm[w][8*k +: 8] = ib.wdata_i[8*k +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("a_rvalid", 32'(ia.rvalid_o), 32'(qa.size() != 0));
    chk("b_rvalid", 32'(ib.rvalid_o), 32'(qb.size() != 0));
    if (qa.size() != 0) begin
      chk("a_rdata", ia.rdata_o, qa[0].d);
      chk("a_err", 32'(ia.err_o), 32'(qa[0].e));
    end
    if (qb.size() != 0) begin
      chk("b_rdata", ib.rdata_o, qb[0].d);
      chk("b_err", 32'(ib.err_o), 32'(qb[0].e));
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 15)) * 4;
    case ($urandom_range(0, 9))
      0: return w + 32'($urandom_range(1, 3));
      1: return w | (32'h4000 << $urandom_range(0, 17));
      default: return w;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mm[i] = 'x;
    ia.we_i    = 1'b0;
    ia.be_i    = '0;
    ia.wdata_i = '0;
    set_a(0, 0, 1);
    set_b(0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    chk("rst_a_rdata", ia.rdata_o, 32'h0);
    chk("rst_a_err", 32'(ia.err_o), 32'h0);
    chk("rst_b_rdata", ib.rdata_o, 32'h0);
    chk("rst_b_err", 32'(ib.err_o), 32'h0);
    rst_n = 1'b1;

    set_b(1, 1, 32'h14, 4'hf, 32'hdeadbeef, 1); cyc();
    set_b(1, 1, 32'h20, 4'hf, 32'h0, 1);        cyc();
    set_b(1, 1, 32'h0, 4'hf, 32'h11111111, 1);  cyc();
    set_b(1, 1, 32'h3ffc, 4'hf, 32'h22222222, 1); cyc();
    set_b(1, 1, 32'h8, 4'hf, 32'hcafef00d, 1);  cyc();
    set_b(0, 0, 0, 0, 0, 1);

    set_a(1, 32'h14, 1); cyc();
    chk("a_read5", ia.rdata_o, 32'hdeadbeef);
    chk("a_read5_err", 32'(ia.err_o), 32'h0);
    set_a(0, 0, 1);

    set_b(1, 1, 32'h14, 4'b0011, 32'h12345678, 1); cyc();
    chk("b_rdfirst", ib.rdata_o, 32'hdeadbeef);
    set_b(1, 1, 32'h14, 4'b0000, 32'hffffffff, 1); cyc();
    chk("b_be0_resp", ib.rdata_o, 32'hdead5678);
    set_b(1, 0, 32'h14, 4'h0, 32'h0, 1); cyc();
    chk("b_merge", ib.rdata_o, 32'hdead5678);

    set_a(1, 32'h20, 1);
    set_b(1, 1, 32'h20, 4'hf, 32'ha5a5a5a5, 1); cyc();
    chk("coll_a_old", ia.rdata_o, 32'h0);
    set_b(0, 0, 0, 0, 0, 1);
    cyc();
    chk("coll_a_new", ia.rdata_o, 32'ha5a5a5a5);
    set_a(0, 0, 1);

    set_b(1, 1, 32'h4002, 4'hf, 32'hffffffff, 1); cyc();
    chk("mis_err", 32'(ib.err_o), 32'h1);
    chk("mis_rdata", ib.rdata_o, 32'h0);
    set_b(1, 1, 32'h4000, 4'hf, 32'hffffffff, 1); cyc();
    chk("oor_err", 32'(ib.err_o), 32'h1);
    chk("oor_rdata", ib.rdata_o, 32'h0);
    set_b(1, 0, 32'h0, 4'h0, 32'h0, 1); cyc();
    chk("word0_keep", ib.rdata_o, 32'h11111111);
    set_b(1, 0, 32'h3ffc, 4'h0, 32'h0, 1); cyc();
    chk("word4095_keep", ib.rdata_o, 32'h22222222);
    set_b(0, 0, 0, 0, 0, 1); cyc();

    set_a(1, 32'h14, 0); cyc();
    chk("bp_first", ia.rdata_o, 32'hdead5678);
    set_a(1, 32'h20, 0); cyc();
    chk("bp_hold1", ia.rdata_o, 32'hdead5678);
    chk("bp_gnt_low", 32'(ia.gnt_o), 32'h0);
    cyc();
    chk("bp_hold2", ia.rdata_o, 32'hdead5678);
    set_a(1, 32'h20, 1); cyc();
    chk("bp_resp2", ia.rdata_o, 32'ha5a5a5a5);
    set_a(1, 32'h0, 1); cyc();
    chk("bp_resp3", ia.rdata_o, 32'h11111111);
    set_a(0, 0, 1); cyc();
    chk("bp_drain", 32'(ia.rvalid_o), 32'h0);

    set_b(1, 1, 32'h8, 4'hf, 32'hffffffff, 1);
    rst_n = 1'b0;
    cyc();
    chk("rst_wr_rvalid", 32'(ib.rvalid_o), 32'h0);
    rst_n = 1'b1;
    set_b(1, 0, 32'h8, 4'h0, 32'h0, 1); cyc();
    chk("rst_wr_dropped", ib.rdata_o, 32'hcafef00d);

    for (int i = 0; i < 600; i++) begin
      set_a(1'($urandom), rand_addr(), $urandom_range(0, 3) != 0);
      set_b(1'($urandom), 1'($urandom), rand_addr(),
            4'($urandom), $urandom,
            $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
